uart_msg_sender: RTL and testbench

//  Host-side sender feeding uart_transmitter: accepts a multi-byte display message
//  (e.g. 16'h1234 = digits "1234") over a valid/ready handshake. Splits it into bytes,

---
 rtl/uart_msg_sender_if.sv | 28 ++
 rtl/uart_msg_sender.sv | 165 ++++++++++++++++
 tb/tb_uart_msg_sender.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_sender_if.sv
// Handshake and transmitter-side signal bundle for uart_msg_sender.
interface uart_msg_sender_if #(
    parameter int unsigned NUM_BYTES = 2
);
    localparam int unsigned MSG_W = 8 * NUM_BYTES;

    logic [MSG_W-1:0] msg_data;
    logic             msg_valid;
    logic             msg_ready;
    logic             msg_done;
    logic             msg_error;
    logic [7:0]       Tx_DATA;
    logic             TX_WR;
    logic             TX_EN;
    logic             Tx_BUSY;

    // Sender's view: takes messages and transmitter status, drives strobes.
    modport master (
        input  msg_data, msg_valid, Tx_BUSY,
        output msg_ready, msg_done, msg_error, Tx_DATA, TX_WR, TX_EN
    );

    // Environment's view: host plus transmitter.
    modport slave (
        output msg_data, msg_valid, Tx_BUSY,
        input  msg_ready, msg_done, msg_error, Tx_DATA, TX_WR, TX_EN
    );
endinterface

// File: rtl/uart_msg_sender.sv
// Splits a multi-byte message into MSB-first bytes and strobes each into a UART transmitter.
module uart_msg_sender #(
    parameter int unsigned NUM_BYTES    = 2,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    uart_msg_sender_if.master  bus
);
    localparam int unsigned MSG_W    = 8 * NUM_BYTES;
    localparam int unsigned CNT_MAX  = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [MSG_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_wr_q, tx_wr_d;
    logic             tx_en_q, tx_en_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             accept;
    logic             byte_done;
    logic [MSG_W-1:0] shifted;
    logic [CNT_W-1:0] cnt_inc;

    // State and output registers; reset aborts any message without a done/error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            tx_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            tx_en_q   <= tx_en_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state and output logic; a byte is written in the same edge the transmitter is seen idle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        tx_en_d   = 1'b1;
        done_d    = 1'b0;
        error_d   = 1'b0;
        byte_done = 1'b0;
        shifted   = shift_q << 8;
        cnt_inc   = cnt_q + CNT_W'(1);
        accept    = (state_q == IDLE) && bus.msg_valid && ready_q;
        // Ready drops on the accepting edge and rises one cycle after returning to IDLE.
        ready_d   = (state_q == IDLE) && tx_en_q && !accept;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = bus.msg_data;
                    idx_d   = '0;
                    if (!bus.Tx_BUSY) begin
                        tx_data_d = bus.msg_data[MSG_W-1 -: 8];
                        tx_wr_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT_ACK;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (!bus.Tx_BUSY) begin
                    tx_data_d = shift_q[MSG_W-1 -: 8];
                    tx_wr_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.Tx_BUSY) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                        error_d   = 1'b1;
                        tx_data_d = 8'h00;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.Tx_BUSY) begin
                    if (GAP_CYCLES == 0) begin
                        byte_done = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(GAP_CYCLES)) begin
                    byte_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Advance to the next byte or finish the message.
        if (byte_done) begin
            if (idx_q < IDX_W'(NUM_BYTES - 1)) begin
                idx_d   = idx_q + IDX_W'(1);
                shift_d = shifted;
                if (!bus.Tx_BUSY) begin
                    tx_data_d = shifted[MSG_W-1 -: 8];
                    tx_wr_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_ACK;
                end else begin
                    state_d = SEND;
                end
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    assign bus.Tx_DATA   = tx_data_q;
    assign bus.TX_WR     = tx_wr_q;
    assign bus.TX_EN     = tx_en_q;
    assign bus.msg_ready = ready_q;
    assign bus.msg_done  = done_q;
    assign bus.msg_error = error_q;
endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed bench for uart_msg_sender: one instance with a gap, one with no gap.
module tb_uart_msg_sender;
    localparam int unsigned NB    = 2;
    localparam int unsigned GAP_A = 4;
    localparam int unsigned TO    = 10;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    uart_msg_sender_if #(.NUM_BYTES(NB)) a ();
    uart_msg_sender_if #(.NUM_BYTES(NB)) b ();

    uart_msg_sender #(.NUM_BYTES(NB), .GAP_CYCLES(GAP_A), .BUSY_TIMEOUT(TO)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    uart_msg_sender #(.NUM_BYTES(NB), .GAP_CYCLES(0), .BUSY_TIMEOUT(TO)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter on instance a acknowledges the strobed byte, then the gap runs out.
    task automatic serve_a(input logic [7:0] next_byte, input bit last);
        a.Tx_BUSY = 1'b1;
        tick();
        check("wr_one_cycle", 32'(a.TX_WR), 32'd0);
        a.Tx_BUSY = 1'b0;
        tick();
        for (int i = 0; i < int'(GAP_A) - 1; i++) tick();
        check("gap_no_wr", 32'(a.TX_WR), 32'd0);
        check("gap_no_done", 32'(a.msg_done), 32'd0);
        tick();
        if (last) begin
            check("done_pulse", 32'(a.msg_done), 32'd1);
            check("done_no_wr", 32'(a.TX_WR), 32'd0);
            check("done_not_ready", 32'(a.msg_ready), 32'd0);
            check("done_no_error", 32'(a.msg_error), 32'd0);
        end else begin
            check("next_wr", 32'(a.TX_WR), 32'd1);
            check("next_data", 32'(a.Tx_DATA), 32'(next_byte));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        a.msg_data  = '0;
        a.msg_valid = 1'b0;
        a.Tx_BUSY   = 1'b0;
        b.msg_data  = '0;
        b.msg_valid = 1'b0;
        b.Tx_BUSY   = 1'b0;
        #1 reset = 1'b0;
        #1;
        // Reset values
        check("rst_tx_en", 32'(a.TX_EN), 32'd0);
        check("rst_tx_wr", 32'(a.TX_WR), 32'd0);
        check("rst_tx_data", 32'(a.Tx_DATA), 32'h00);
        check("rst_ready", 32'(a.msg_ready), 32'd0);
        check("rst_done", 32'(a.msg_done), 32'd0);
        check("rst_error", 32'(a.msg_error), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rel_tx_en", 32'(a.TX_EN), 32'd1);
        check("rel_ready_low", 32'(a.msg_ready), 32'd0);
        tick();
        check("rel_ready", 32'(a.msg_ready), 32'd1);

        // 1: 16'h1234 goes out as 12 then 34, one done
        a.msg_data  = 16'h1234;
        a.msg_valid = 1'b1;
        tick();
        a.msg_valid = 1'b0;
        check("t1_wr0", 32'(a.TX_WR), 32'd1);
        check("t1_data0", 32'(a.Tx_DATA), 32'h12);
        check("t1_ready_low", 32'(a.msg_ready), 32'd0);
        serve_a(8'h34, 1'b0);
        serve_a(8'h00, 1'b1);
        tick();
        check("t1_done_once", 32'(a.msg_done), 32'd0);
        check("t1_ready_back", 32'(a.msg_ready), 32'd1);
        check("t1_data_hold", 32'(a.Tx_DATA), 32'h34);

        // 2: transmitter busy at accept defers the strobe
        a.Tx_BUSY   = 1'b1;
        a.msg_data  = 16'hFFFF;
        a.msg_valid = 1'b1;
        tick();
        a.msg_valid = 1'b0;
        check("t2_accepted", 32'(a.msg_ready), 32'd0);
        check("t2_no_wr0", 32'(a.TX_WR), 32'd0);
        tick();
        tick();
        check("t2_no_wr2", 32'(a.TX_WR), 32'd0);
        a.Tx_BUSY = 1'b0;
        tick();
        check("t2_wr", 32'(a.TX_WR), 32'd1);
        check("t2_data", 32'(a.Tx_DATA), 32'hFF);
        serve_a(8'hFF, 1'b0);
        serve_a(8'h00, 1'b1);
        tick();

        // 3: no busy response -> error after TO cycles, second byte dropped
        a.msg_data  = 16'hABCD;
        a.msg_valid = 1'b1;
        tick();
        a.msg_valid = 1'b0;
        check("t3_wr", 32'(a.TX_WR), 32'd1);
        check("t3_data", 32'(a.Tx_DATA), 32'hAB);
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        check("t3_no_early_err", 32'(a.msg_error), 32'd0);
        check("t3_data_stable", 32'(a.Tx_DATA), 32'hAB);
        tick();
        check("t3_error", 32'(a.msg_error), 32'd1);
        check("t3_no_done", 32'(a.msg_done), 32'd0);
        check("t3_data_clr", 32'(a.Tx_DATA), 32'h00);
        check("t3_not_ready", 32'(a.msg_ready), 32'd0);
        tick();
        check("t3_err_pulse", 32'(a.msg_error), 32'd0);
        check("t3_ready", 32'(a.msg_ready), 32'd1);
        check("t3_no_cd", 32'(a.TX_WR), 32'd0);

        // 4: second offer held during a message is taken only after done
        a.msg_data  = 16'h1234;
        a.msg_valid = 1'b1;
        tick();
        a.msg_data  = 16'h5678;
        check("t4_data0", 32'(a.Tx_DATA), 32'h12);
        serve_a(8'h34, 1'b0);
        serve_a(8'h00, 1'b1);
        tick();
        check("t4_ready", 32'(a.msg_ready), 32'd1);
        check("t4_no_wr_yet", 32'(a.TX_WR), 32'd0);
        tick();
        a.msg_valid = 1'b0;
        check("t4_wr_56", 32'(a.TX_WR), 32'd1);
        check("t4_data_56", 32'(a.Tx_DATA), 32'h56);
        serve_a(8'h78, 1'b0);
        serve_a(8'h00, 1'b1);
        tick();

        // 5: asynchronous reset while the first byte is in flight
        a.msg_data  = 16'h1234;
        a.msg_valid = 1'b1;
        tick();
        a.msg_valid = 1'b0;
        a.Tx_BUSY   = 1'b1;
        tick();
        check("t5_pre_data", 32'(a.Tx_DATA), 32'h12);
        #2 reset = 1'b0;
        #1;
        check("t5_async_data", 32'(a.Tx_DATA), 32'h00);
        check("t5_async_en", 32'(a.TX_EN), 32'd0);
        check("t5_async_ready", 32'(a.msg_ready), 32'd0);
        a.Tx_BUSY = 1'b0;
        tick();
        tick();
        check("t5_no_done", 32'(a.msg_done), 32'd0);
        check("t5_no_err", 32'(a.msg_error), 32'd0);
        reset = 1'b1;
        tick();
        check("t5_en", 32'(a.TX_EN), 32'd1);
        check("t5_ready_low", 32'(a.msg_ready), 32'd0);
        tick();
        check("t5_ready", 32'(a.msg_ready), 32'd1);
        check("t5_idle_wr", 32'(a.TX_WR), 32'd0);

        // 6: zero gap -> next strobe on the edge that sees busy low
        b.msg_data  = 16'h1234;
        b.msg_valid = 1'b1;
        tick();
        b.msg_valid = 1'b0;
        check("t6_wr0", 32'(b.TX_WR), 32'd1);
        check("t6_data0", 32'(b.Tx_DATA), 32'h12);
        b.Tx_BUSY = 1'b1;
        tick();
        b.Tx_BUSY = 1'b0;
        tick();
        check("t6_wr1", 32'(b.TX_WR), 32'd1);
        check("t6_data1", 32'(b.Tx_DATA), 32'h34);
        b.Tx_BUSY = 1'b1;
        tick();
        b.Tx_BUSY = 1'b0;
        tick();
        check("t6_done", 32'(b.msg_done), 32'd1);
        check("t6_no_wr", 32'(b.TX_WR), 32'd0);
        tick();
        check("t6_ready", 32'(b.msg_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
